shift_arbiter: RTL and testbench
================================

# shift_arbiter

Shares one N-bit shift unit (logical right, logical left, arithmetic right) between two requesters. Each requester uses a valid/ready handshake. The block applies round-robin arbitration and registers each result in a single-entry output buffer with its own valid/ready handshake. It sits between the ALU-side issue logic and the shared shifter datapath, so a single shifter instance serves both the integer pipe and the address/immediate unit.

## Interface
Parameters:
- N, 32, datapath width; only N=32 is required and verified.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; asserting it clears all state immediately.
- a_valid  input  1  requester A has an operation.
- a_ready  output  1  A's operation is accepted this cycle.
- a_in  input  N  A's operand.
- a_shamt  input  $clog2(N)  A's shift amount.
- a_op  input  2  A's operation: 00 SRL, 01 SLL, 10 SRA, 11 pass-through.
- b_valid, b_ready, b_in, b_shamt, b_op: same widths and meaning as the A ports, for requester B.
- res_valid  output  1  the result buffer holds a result.
- res_ready  input  1  the consumer takes the result this cycle.
- res_out  output  N  the shifted result.
- res_id  output  1  which requester produced the result: 0 = A, 1 = B.
- done_count  output  16  count of results consumed; wraps modulo 2^16.

## Operation
- Two buffer states:
  - EMPTY: res_valid=0.
  - FULL: res_valid=1.
- can_accept = EMPTY, or (FULL and res_ready).
- Grant is combinational and computed only when can_accept:
  - Only one of a_valid/b_valid is high: that requester is granted.
  - Both are high: the requester not granted most recently wins. A pointer last_id holds the most recent grant.
  - A not-granted requester sees ready=0, regardless of its valid.
- a_ready/b_ready are never both 1. A ready is never 1 when the matching valid is 0.
- On a granted edge:
  - res_out <= shift(in, shamt, op).
  - res_id <= winner.
  - last_id <= winner.
  - State becomes FULL.
- Consume without a new grant (FULL, res_ready=1, no valid requester): state becomes EMPTY. res_out and res_id hold their last values.
- Shift rules:
  - SRL fills with zeros.
  - SLL fills with zeros.
  - SRA fills with in[N-1].
  - shamt=0 returns in unchanged.
  - op 11 returns in unchanged and ignores shamt.
- done_count increments on every edge where res_valid and res_ready are both 1. It rolls over from 0xFFFF to 0x0000.
- While FULL and res_ready=0: res_out and res_id are held, and both ready outputs are 0 (back-pressure).

## Timing
- Reset values: res_valid=0, res_out=0, res_id=0, done_count=0, last_id=1 (A wins the first tie), state EMPTY.
- Reset asserted mid-operation: any buffered result is discarded, with no handshake completion.
- Latency: an operation accepted at edge k has res_valid=1 and a valid res_out immediately after edge k (1 cycle).
- Throughput: one result per cycle when res_ready is held high. Consume and accept in the same cycle are permitted.
- a_ready/b_ready depend combinationally on a_valid, b_valid, res_valid, res_ready and last_id. They do not depend on operand data.
- Requester obligations:
  - in, shamt and op must be stable while valid=1 and ready=0.
  - valid must not drop before ready.
- No combinational path from any requester input to res_out, res_id or res_valid.

## Test plan
- Reset, then A only: a_in=0x80000000, a_shamt=4, a_op=SRA, res_ready=1 -> the next cycle gives res_out=0xF8000000, res_id=0, done_count=1 one cycle later.
- Both valid every cycle, res_ready=1:
  - A: SRL 0xFFFFFFFF by 31.
  - B: SLL 0x00000001 by 31.
  - -> grants alternate A,B,A,B starting with A.
  - -> results alternate 0x00000001 (id 0) and 0x80000000 (id 1).
- Back-pressure: fill the buffer, hold res_ready=0 for 5 cycles with both valid -> a_ready=b_ready=0, res_out held stable; release -> the next grant goes to the requester that was not granted last.
- Edge cases:
  - shamt=0 with each of SRL/SLL/SRA on 0xA5A5A5A5 -> 0xA5A5A5A5.
  - op=11 with shamt=7 -> operand unchanged.
  - SRA 0x7FFFFFFF by 31 -> 0x00000000.
- Assert rst low while FULL with res_ready=0 -> res_valid=0, res_out=0 and done_count=0 immediately (asynchronously). After release, the first tie goes to A.
- Run 65,537 consumed results with res_ready=1 -> done_count wraps to 0x0001. Throughout the run:
  - A scoreboard matches every result against a reference shift model.
  - No ready is ever raised without the matching valid.

Source files
------------

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter
// Purpose  : Round-robin sharing of one SRL/SLL/SRA shift unit between two
//            valid/ready requesters, with a single-entry registered result
//            buffer carrying its own valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module shift_arbiter #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,        // asynchronous, active-low
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [N-1:0]  a_in,
    input  logic [SW-1:0] a_shamt,
    input  logic [1:0]    a_op,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [N-1:0]  b_in,
    input  logic [SW-1:0] b_shamt,
    input  logic [1:0]    b_op,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  res_out,
    output logic          res_id,
    output logic [15:0]   done_count
);

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t    state_q, state_d;
    logic [N-1:0]  res_out_q, res_out_d;
    logic          res_id_q, res_id_d;
    logic          last_id_q, last_id_d;
    logic [15:0]   done_count_q, done_count_d;

    logic          can_accept;
    logic          grant_a;
    logic          grant_b;
    logic          consume;
    logic [N-1:0]  sel_in;
    logic [SW-1:0] sel_shamt;
    logic [1:0]    sel_op;
    logic [N-1:0]  shift_res;

    // Round-robin grant: a tie goes to whichever side did not win last time.
    always_comb begin
        can_accept = (state_q == EMPTY) || res_ready;
        grant_a    = can_accept && a_valid && (!b_valid || last_id_q);
        grant_b    = can_accept && b_valid && (!a_valid || !last_id_q);
        consume    = (state_q == FULL) && res_ready;
    end

    // Operand mux (B only when B actually won) feeding the shared shifter.
    always_comb begin
        sel_in    = grant_b ? b_in    : a_in;
        sel_shamt = grant_b ? b_shamt : a_shamt;
        sel_op    = grant_b ? b_op    : a_op;
        case (sel_op)
            OP_SRL:  shift_res = sel_in >> sel_shamt;
            OP_SLL:  shift_res = sel_in << sel_shamt;
            OP_SRA:  shift_res = N'($signed(sel_in) >>> sel_shamt);
            default: shift_res = sel_in;
        endcase
    end

    // Next-state for the result buffer, round-robin pointer and counter.
    always_comb begin
        state_d      = state_q;
        res_out_d    = res_out_q;
        res_id_d     = res_id_q;
        last_id_d    = last_id_q;
        done_count_d = done_count_q;
        if (grant_a || grant_b) begin
            state_d   = FULL;
            res_out_d = shift_res;
            res_id_d  = grant_b;
            last_id_d = grant_b;
        end else if (consume) begin
            state_d = EMPTY;
        end
        if (consume) begin
            done_count_d = done_count_q + 16'd1;
        end
    end

    // State registers; last_id resets to B so that A takes the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= EMPTY;
            res_out_q    <= '0;
            res_id_q     <= 1'b0;
            last_id_q    <= 1'b1;
            done_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            res_out_q    <= res_out_d;
            res_id_q     <= res_id_d;
            last_id_q    <= last_id_d;
            done_count_q <= done_count_d;
        end
    end

    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign res_valid  = (state_q == FULL);
    assign res_out    = res_out_q;
    assign res_id     = res_id_q;
    assign done_count = done_count_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_arbiter
// Purpose  : Self-checking bench for shift_arbiter against a behavioural
//            arithmetic shift model and a transaction-level buffer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [31:0] a_in = '0, b_in = '0;
    logic [4:0]  a_shamt = '0, b_shamt = '0;
    logic [1:0]  a_op = '0, b_op = '0;
    logic        res_valid, res_ready = 1'b0, res_id;
    logic [31:0] res_out;
    logic [15:0] done_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state (transaction level)
    logic        m_valid;
    logic [31:0] m_out;
    logic        m_id;
    logic        m_last;
    int          m_done;

    shift_arbiter #(.N(32)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_in(a_in), .a_shamt(a_shamt), .a_op(a_op),
        .b_valid(b_valid), .b_ready(b_ready), .b_in(b_in), .b_shamt(b_shamt), .b_op(b_op),
        .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out),
        .res_id(res_id), .done_count(done_count)
    );

    always #5 clk = ~clk;

    // Shift semantics by plain arithmetic: divide / multiply by 2^sh.
    function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] sh,
                                              input logic [1:0] op);
        longint p, v, s, q;
        p = longint'(1) << sh;
        v = longint'(x);
        case (op)
            2'd0: q = v / p;
            2'd1: q = (v * p) % (longint'(1) << 32);
            2'd2: begin
                s = x[31] ? v - (longint'(1) << 32) : v;
                q = (s >= 0) ? s / p : -((-s + p - 1) / p);
            end
            default: q = v;
        endcase
        return 32'(q);
    endfunction

    // Expected grants from the arbitration rules and current inputs.
    task automatic model_grant(output logic ga, output logic gb);
        logic can;
        can = !m_valid || res_ready;
        ga = 1'b0;
        gb = 1'b0;
        if (can) begin
            if (a_valid && b_valid) begin
                if (m_last) ga = 1'b1; else gb = 1'b1;
            end else begin
                ga = a_valid;
                gb = b_valid;
            end
        end
    endtask

    // Advance one clock edge and update the model; no checking here.
    task automatic tick(output logic ga, output logic gb);
        logic consume;
        model_grant(ga, gb);
        consume = m_valid && res_ready;
        @(posedge clk);
        if (ga) begin
            m_valid = 1'b1; m_out = ref_shift(a_in, a_shamt, a_op); m_id = 1'b0; m_last = 1'b0;
        end else if (gb) begin
            m_valid = 1'b1; m_out = ref_shift(b_in, b_shamt, b_op); m_id = 1'b1; m_last = 1'b1;
        end else if (consume) begin
            m_valid = 1'b0;
        end
        if (consume) m_done = m_done + 1;
        #1;
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_out = '0; m_id = 1'b0; m_last = 1'b1; m_done = 0;
    endtask

    task automatic apply_reset();
        a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        vectors++;
        if (res_valid !== 1'b0 || res_out !== 32'h0 || res_id !== 1'b0 || done_count !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_values: got valid=%b out=%h id=%b cnt=%h want 0/0/0/0",
                     res_valid, res_out, res_id, done_count);
        end
        vectors++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got a=%b b=%b want 0 0", a_ready, b_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_first_sra();
        logic ga, gb;
        a_valid = 1'b1; a_in = 32'h8000_0000; a_shamt = 5'd4; a_op = 2'b10; res_ready = 1'b1;
        #1;
        vectors++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL sra_grant: got a=%b b=%b want 1 0", a_ready, b_ready);
        end
        tick(ga, gb);
        a_valid = 1'b0;
        vectors++;
        if (res_valid !== 1'b1 || res_out !== 32'hF800_0000 || res_id !== 1'b0 || done_count !== 16'd0) begin
            miscompares++;
            $display("FAIL sra_result: got v=%b out=%h id=%b cnt=%0d want 1 f8000000 0 0",
                     res_valid, res_out, res_id, done_count);
        end
        tick(ga, gb);
        vectors++;
        if (done_count !== 16'd1 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sra_consume: got cnt=%0d v=%b want 1 0", done_count, res_valid);
        end
    endtask

    task automatic test_alternate();
        logic ga, gb;
        logic [31:0] want;
        apply_reset();
        a_valid = 1'b1; a_in = 32'hFFFF_FFFF; a_shamt = 5'd31; a_op = 2'b00;
        b_valid = 1'b1; b_in = 32'h0000_0001; b_shamt = 5'd31; b_op = 2'b01;
        res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            vectors++;
            if (a_ready !== (k % 2 == 0) || b_ready !== (k % 2 == 1)) begin
                miscompares++;
                $display("FAIL alt_grant[%0d]: got a=%b b=%b want a=%0d", k, a_ready, b_ready, (k % 2 == 0));
            end
            tick(ga, gb);
            want = (k % 2 == 0) ? 32'h0000_0001 : 32'h8000_0000;
            vectors++;
            if (res_out !== want || res_id !== (k % 2 == 1) || res_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL alt_result[%0d]: got out=%h id=%b want %h %0d", k, res_out, res_id, want, (k % 2 == 1));
            end
        end
    endtask

    task automatic test_back_pressure();
        logic ga, gb;
        logic [31:0] held;
        logic        held_id;
        res_ready = 1'b0;
        held = res_out;
        held_id = res_id;
        for (int k = 0; k < 5; k++) begin
            #1;
            vectors++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_ready[%0d]: got a=%b b=%b want 0 0", k, a_ready, b_ready);
            end
            tick(ga, gb);
            vectors++;
            if (res_out !== held || res_id !== held_id || res_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got out=%h id=%b v=%b want %h %b 1", k, res_out, res_id, res_valid, held, held_id);
            end
        end
        res_ready = 1'b1;
        #1;
        vectors++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release_grant: got a=%b b=%b want 1 0", a_ready, b_ready);
        end
        tick(ga, gb);
        vectors++;
        if (res_id !== 1'b0 || res_out !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL bp_release_result: got id=%b out=%h want 0 00000001", res_id, res_out);
        end
        b_valid = 1'b0;
    endtask

    task automatic test_edge_shifts();
        logic ga, gb;
        logic [31:0] ins [6] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h12345678, 32'h7FFFFFFF, 32'hF0000001};
        logic [4:0]  shs [6] = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd31, 5'd31};
        logic [1:0]  ops [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2};
        logic [31:0] exp [6] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h12345678, 32'h0, 32'hFFFFFFFF};
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a_valid = 1'b1; a_in = ins[k]; a_shamt = shs[k]; a_op = ops[k];
            #1;
            vectors++;
            if (a_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL edge_grant[%0d]: got a_ready=%b want 1", k, a_ready);
            end
            tick(ga, gb);
            vectors++;
            if (res_out !== exp[k] || res_id !== 1'b0) begin
                miscompares++;
                $display("FAIL edge_shift[%0d]: got %h id=%b want %h 0", k, res_out, res_id, exp[k]);
            end
        end
        a_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        logic ga, gb;
        a_valid = 1'b1; a_in = 32'hDEAD_BEEF; a_shamt = 5'd3; a_op = 2'b01; res_ready = 1'b0;
        tick(ga, gb);
        a_valid = 1'b0;
        vectors++;
        if (res_valid !== 1'b1 || done_count === 16'd0) begin
            miscompares++;
            $display("FAIL ar_prefill: got v=%b cnt=%0d want 1 nonzero", res_valid, done_count);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (res_valid !== 1'b0 || res_out !== 32'h0 || done_count !== 16'd0 || res_id !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b out=%h cnt=%0d id=%b want 0 0 0 0", res_valid, res_out, done_count, res_id);
        end
        @(negedge clk);
        rst = 1'b1;
        a_valid = 1'b1; a_op = 2'b11; b_valid = 1'b1; b_op = 2'b11; res_ready = 1'b1;
        #1;
        vectors++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ar_first_tie: got a=%b b=%b want 1 0", a_ready, b_ready);
        end
        tick(ga, gb);
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random_wrap();
        logic ga, gb, ega, egb;
        int cyc;
        apply_reset();
        res_ready = 1'b1;
        ga = 1'b0; gb = 1'b0; cyc = 0;
        while (m_done < 65537 && cyc < 90000) begin
            if (!a_valid || ga) begin
                a_valid = ($urandom_range(0, 7) != 0);
                a_in = rand_operand(); a_shamt = 5'($urandom_range(0, 31)); a_op = 2'($urandom_range(0, 3));
            end
            if (!b_valid || gb) begin
                b_valid = ($urandom_range(0, 7) != 0);
                b_in = rand_operand(); b_shamt = 5'($urandom_range(0, 31)); b_op = 2'($urandom_range(0, 3));
            end
            #1;
            model_grant(ega, egb);
            vectors++;
            if (a_ready !== ega || b_ready !== egb) begin
                miscompares++;
                $display("FAIL rnd_grant[%0d]: got a=%b b=%b want %b %b", cyc, a_ready, b_ready, ega, egb);
            end
            vectors++;
            if ((a_ready && !a_valid) || (b_ready && !b_valid) || (a_ready && b_ready)) begin
                miscompares++;
                $display("FAIL rnd_ready_rule[%0d]: got a=%b/%b b=%b/%b (ready/valid)", cyc, a_ready, a_valid, b_ready, b_valid);
            end
            tick(ga, gb);
            vectors++;
            if (res_valid !== m_valid || (m_valid && (res_out !== m_out || res_id !== m_id))
                || done_count !== m_done[15:0]) begin
                miscompares++;
                $display("FAIL rnd_result[%0d]: got v=%b out=%h id=%b cnt=%h want %b %h %b %h",
                         cyc, res_valid, res_out, res_id, done_count, m_valid, m_out, m_id, m_done[15:0]);
            end
            cyc++;
        end
        vectors++;
        if (m_done < 65537) begin
            miscompares++;
            $display("FAIL rnd_budget: got %0d consumed results want 65537", m_done);
        end
        a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0;
        #1;
        vectors++;
        if (done_count !== 16'h0001) begin
            miscompares++;
            $display("FAIL wrap_count: got %h want 0001", done_count);
        end
    endtask

    initial begin
        test_reset();
        test_first_sra();
        test_alternate();
        test_back_pressure();
        test_edge_shifts();
        test_async_reset();
        test_random_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
